// File: rtl/bk_add_sched.sv
// Round-robin multi-precision add sequencer around one shared external adder.
// Carry is chained across the words of a burst with a second (+1) adder pass.
module bk_add_sched #(
    parameter int W    = 12,
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_last,
    output logic [2*W-1:0]    add_in,
    input  logic [W:0]        add_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last,
    output logic [IDW-1:0]    rsp_id
);

    typedef enum logic [2:0] {IDLE, WORD, PASS1, PASS2, RESP} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  g, ptr, rr_idx, hi_idx, lo_idx;
    logic            rr_hit, hi_hit, lo_hit;
    logic            cin, hs;
    logic [W-1:0]    op_a, op_b, s1, sum_r, sel_a, sel_b;
    logic            op_last, c1, cout_r, sel_last;

    function automatic logic [2*W-1:0] interleave(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] v;
        for (int k = 0; k < W; k++) begin
            v[2*k]   = a[k];
            v[2*k+1] = b[k];
        end
        return v;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        if (i == IDW'(NREQ-1))
            return '0;
        return i + IDW'(1);
    endfunction

    // First valid requester at or after ptr; fall back to the lowest valid one (wrap).
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int j = NREQ-1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_hit = 1'b1;
                lo_idx = IDW'(j);
                if (j >= int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = IDW'(j);
                end
            end
        end
        rr_hit = lo_hit;
        rr_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (g == IDW'(j)) begin
                sel_a        = req_a[j*W +: W];
                sel_b        = req_b[j*W +: W];
                sel_last     = req_last[j];
                req_ready[j] = (state == WORD) && req_valid[j];
            end
        end
        hs = |req_ready;
    end

    always_comb begin
        state_nxt = state;
        add_in    = '0;
        case (state)
            IDLE:    if (rr_hit) state_nxt = WORD;
            WORD:    if (hs) state_nxt = PASS1;
            PASS1: begin
                add_in    = interleave(op_a, op_b);
                state_nxt = cin ? PASS2 : RESP;
            end
            PASS2: begin
                add_in    = interleave(s1, W'(1));
                state_nxt = RESP;
            end
            RESP:    if (rsp_ready) state_nxt = op_last ? IDLE : WORD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g       <= '0;
            ptr     <= '0;
            cin     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_last <= 1'b0;
            s1      <= '0;
            c1      <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rr_hit) g <= rr_idx;
                WORD: begin
                    if (hs) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_last <= sel_last;
                    end
                end
                PASS1: begin
                    s1 <= add_out[W-1:0];
                    c1 <= add_out[W];
                    if (!cin) begin
                        sum_r  <= add_out[W-1:0];
                        cout_r <= add_out[W];
                    end
                end
                PASS2: begin
                    // c1 and the +1 carry can never both be set, so OR is the true carry.
                    sum_r  <= add_out[W-1:0];
                    cout_r <= c1 | add_out[W];
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (op_last) begin
                            cin <= 1'b0;
                            ptr <= wrap_inc(g);
                        end else begin
                            cin <= cout_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_sum   = sum_r;
    assign rsp_cout  = cout_r;
    assign rsp_last  = op_last;
    assign rsp_id    = g;

endmodule

// File: tb/tb_bk_add_sched.sv
// Scoreboard bench for bk_add_sched: requester drivers push expected words,
// a monitor pops and compares each response; the adder is modelled here.
module tb_bk_add_sched;

    localparam int W    = 12;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_last;
    logic [2*W-1:0]    add_in;
    logic [W:0]        add_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_last;
    logic [IDW-1:0]    rsp_id;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } word_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         last;
        int           id;
        int           acc;
        int           lat;
    } exp_t;

    word_t rq [NREQ][$];
    exp_t  sb [$];
    int    id_log [$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   pass2_hits = 0;
    int   rsp_mode = 0;
    bit   bubbles = 0;
    logic carry = 1'b0;

    bk_add_sched #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .add_in(add_in), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last), .rsp_id(rsp_id)
    );

    function automatic logic [W-1:0] deint_a(input logic [2*W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = v[2*k];
        return r;
    endfunction

    function automatic logic [W-1:0] deint_b(input logic [2*W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = v[2*k+1];
        return r;
    endfunction

    // Behavioural adder attached to the DUT's adder port
    always_comb add_out = {1'b0, deint_a(add_in)} + {1'b0, deint_b(add_in)};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        word_t w;
        w.a = a;
        w.b = b;
        w.last = last;
        rq[i].push_back(w);
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(3))
            0: return '1;
            1: return '0;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic int get_id(input int k);
        if (k < id_log.size())
            return id_log[k];
        return -1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            if (rq[0].size() == 0 && rq[1].size() == 0 && sb.size() == 0 && !rsp_valid)
                done = 1'b1;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // Requester drivers: a handshake seen mid-cycle completes at the next rising edge
    initial begin
        exp_t        e;
        word_t       w;
        logic [W+1:0] full;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("req_ready_onehot", 64'(($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0)), 64'd0);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        w    = rq[i].pop_front();
                        full = {2'b00, w.a} + {2'b00, w.b} + {{(W+1){1'b0}}, carry};
                        e.sum  = full[W-1:0];
                        e.cout = full[W];
                        e.last = w.last;
                        e.id   = i;
                        e.acc  = cyc;
                        e.lat  = carry ? 3 : 2;
                        sb.push_back(e);
                        carry = w.last ? 1'b0 : full[W];
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < NREQ; i++) rq[i].delete();
                carry = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!rst && rq[i].size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
                    req_valid[i]       = 1'b1;
                    req_a[i*W +: W]    = rq[i][0].a;
                    req_b[i*W +: W]    = rq[i][0].b;
                    req_last[i]        = rq[i][0].last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_a[i*W +: W]    = W'($urandom);
                    req_b[i*W +: W]    = W'($urandom);
                    req_last[i]        = 1'($urandom_range(1));
                end
            end
            rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        end
    end

    // Response monitor
    initial begin
        exp_t               e;
        logic               prev_valid;
        logic               stalled;
        logic [W+IDW+2:0]   snap;
        prev_valid = 1'b0;
        stalled    = 1'b0;
        snap       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_valid = 1'b0;
                stalled    = 1'b0;
            end else begin
                if (stalled)
                    chk("bp_hold", 64'({rsp_valid, rsp_sum, rsp_cout, rsp_last, rsp_id}), 64'(snap));
                if (rsp_valid && !rsp_ready) begin
                    stall_cnt++;
                    chk("bp_quiet", 64'({req_ready, add_in}), 64'd0);
                end
                if (rsp_valid && !prev_valid) begin
                    if (sb.size() == 0)
                        chk("latency_no_expect", 64'd1, 64'd0);
                    else
                        chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_sum), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                        chk("rsp_last", 64'(rsp_last), 64'(e.last));
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    end
                    id_log.push_back(int'(rsp_id));
                end
                if (deint_a(add_in) == '0 && deint_b(add_in) == W'(1))
                    pass2_hits++;
                stalled    = rsp_valid && !rsp_ready;
                snap       = {rsp_valid, rsp_sum, rsp_cout, rsp_last, rsp_id};
                prev_valid = rsp_valid;
            end
        end
    end

    initial begin
        int  base;
        int  p;
        int  s;
        bit  seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", 64'({req_ready, add_in, rsp_valid, rsp_sum, rsp_cout, rsp_last, rsp_id}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // single word with carry-out
        base = id_log.size();
        push(0, 12'hFFF, 12'h001, 1'b1);
        wait_idle("t1_done", 200);
        chk("t1_id", 64'(get_id(base)), 64'd0);

        // carry chained into second word via the +1 pass
        base = id_log.size();
        p = pass2_hits;
        push(1, 12'hFFF, 12'h001, 1'b0);
        push(1, 12'h000, 12'h000, 1'b1);
        wait_idle("t2_done", 200);
        chk("t2_pass2_seen", 64'(pass2_hits != p), 64'd1);
        chk("t2_id0", 64'(get_id(base)), 64'd1);
        chk("t2_id1", 64'(get_id(base+1)), 64'd1);

        // carry produced by the +1 pass only
        push(1, 12'h800, 12'h800, 1'b0);
        push(1, 12'hFFF, 12'h000, 1'b1);
        wait_idle("t3_done", 200);

        // round robin with single-word bursts
        base = id_log.size();
        for (int k = 0; k < 2; k++) begin
            push(0, rand_word(), rand_word(), 1'b1);
            push(1, rand_word(), rand_word(), 1'b1);
        end
        wait_idle("t4_done", 400);
        chk("rr_0", 64'(get_id(base)), 64'd0);
        chk("rr_1", 64'(get_id(base+1)), 64'd1);
        chk("rr_2", 64'(get_id(base+2)), 64'd0);
        chk("rr_3", 64'(get_id(base+3)), 64'd1);

        // grant lock over a 3-word burst
        base = id_log.size();
        for (int k = 0; k < 3; k++) push(0, rand_word(), rand_word(), 1'(k == 2));
        push(1, rand_word(), rand_word(), 1'b1);
        wait_idle("t5_done", 400);
        chk("lock_0", 64'(get_id(base)), 64'd0);
        chk("lock_1", 64'(get_id(base+1)), 64'd0);
        chk("lock_2", 64'(get_id(base+2)), 64'd0);
        chk("lock_3", 64'(get_id(base+3)), 64'd1);

        // back-pressure held for several cycles
        rsp_mode = 2;
        s = stall_cnt;
        push(0, 12'h3A5, 12'h15C, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = rsp_valid;
        end
        chk("bp_rsp_seen", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        rsp_mode = 0;
        wait_idle("t6_done", 200);
        chk("bp_stall_cycles", 64'((stall_cnt - s) >= 5), 64'd1);

        // reset in the middle of a burst whose first word carried out
        base = id_log.size();
        push(0, 12'hFFF, 12'h001, 1'b0);
        push(0, 12'h123, 12'h456, 1'b0);
        push(0, 12'h001, 12'h002, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = (id_log.size() > base);
        end
        chk("t7_first_rsp", 64'(seen), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({req_ready, add_in, rsp_valid, rsp_sum, rsp_cout, rsp_last, rsp_id}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        base = id_log.size();
        push(0, 12'h001, 12'h001, 1'b1);
        push(1, 12'h001, 12'h001, 1'b1);
        wait_idle("t7_done", 200);
        chk("post_rst_id0", 64'(get_id(base)), 64'd0);
        chk("post_rst_id1", 64'(get_id(base+1)), 64'd1);

        // randomized bursts with bubbles and random response stalls
        rsp_mode = 1;
        bubbles  = 1'b1;
        for (int k = 0; k < 120; k++) begin
            int i;
            int len;
            i   = $urandom_range(NREQ-1);
            len = $urandom_range(4, 1);
            for (int j = 0; j < len; j++)
                push(i, rand_word(), rand_word(), 1'(j == len-1));
        end
        wait_idle("random_done", 30000);
        rsp_mode = 0;
        bubbles  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
